// File: rtl/priority_bit_scanner.sv
// priority_bit_scanner: accepts a request vector and emits the index of each set bit,
// one per output beat, in LSB-first or MSB-first priority order.
module priority_bit_scanner #(
    parameter int WIDTH     = 16,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SCAN, ZERO} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work, work_nxt, onehot;

    // Scan away from the priority end so the last hit is the winning bit.
    always_comb begin
        out_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (work[MSB_FIRST ? i : WIDTH-1-i]) out_idx = IDX_W'(MSB_FIRST ? i : WIDTH-1-i);
        end
    end

    assign onehot    = WIDTH'(1) << out_idx;
    assign out_valid = state != IDLE;
    assign busy      = state != IDLE;
    assign in_ready  = state == IDLE && !abort;
    assign out_none  = state == ZERO;
    assign out_last  = state == ZERO || (state == SCAN && (work & (work - 1'b1)) == '0);

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    work_nxt  = in_vec;
                    state_nxt = in_vec == '0 ? ZERO : SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    work_nxt  = '0;
                end else if (out_ready) begin
                    work_nxt  = work & ~onehot;
                    state_nxt = out_last ? IDLE : SCAN;
                end
            end
            ZERO: begin
                if (abort || out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
        end
    end
endmodule

// File: tb/tb_priority_bit_scanner.sv
// tb_priority_bit_scanner: random and directed stimulus on LSB-first and MSB-first
// instances, checked against a queue-of-expected-beats model.
module tb_priority_bit_scanner;
    localparam int W = 16;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_vec = '0;
    logic         rdy0, vld0, last0, none0, busy0;
    logic         rdy1, vld1, last1, none1, busy1;
    logic [3:0]   idx0, idx1;
    int           n_tests = 0, n_fail = 0;
    int           q0[$], q1[$];

    always #5 clk = ~clk;

    priority_bit_scanner #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_vec(in_vec),
        .abort(abort), .out_valid(vld0), .out_ready(out_ready), .out_idx(idx0),
        .out_last(last0), .out_none(none0), .busy(busy0)
    );

    priority_bit_scanner #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_vec(in_vec),
        .abort(abort), .out_valid(vld1), .out_ready(out_ready), .out_idx(idx1),
        .out_last(last1), .out_none(none1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Queue holds the pending beats: bit index, or -1 for the all-zero beat.
    task automatic check_dut(input string t, input int q[$], input logic [3:0] idx,
                             input logic v, input logic l, input logic n, input logic r, input logic b);
        bit act;
        int h;
        act = q.size() > 0;
        h   = act ? q[0] : 0;
        check({t, ".valid"}, 32'(v), 32'(act));
        check({t, ".busy"},  32'(b), 32'(act));
        check({t, ".ready"}, 32'(r), 32'(!act && !abort));
        check({t, ".idx"},   32'(idx), act && h >= 0 ? h : 0);
        check({t, ".last"},  32'(l), 32'(act && q.size() == 1));
        check({t, ".none"},  32'(n), 32'(act && h < 0));
    endtask

    task automatic check_all();
        check_dut("lsb", q0, idx0, vld0, last0, none0, rdy0, busy0);
        check_dut("msb", q1, idx1, vld1, last1, none1, rdy1, busy1);
    endtask

    task automatic step(input logic v, input logic [W-1:0] vec, input logic ab, input logic rdy);
        @(negedge clk);
        in_valid = v; in_vec = vec; abort = ab; out_ready = rdy;
        #1;
        check_all();
        if (q0.size() > 0) begin
            if (ab) begin
                q0.delete();
                q1.delete();
            end else if (rdy) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
        end else if (v && !ab) begin
            if (vec == '0) begin
                q0.push_back(-1);
                q1.push_back(-1);
            end else begin
                for (int i = 0; i < W; i++) begin
                    if (vec[i]) begin
                        q0.push_back(i);
                        q1.push_front(i);
                    end
                end
            end
        end
        @(posedge clk);
    endtask

    initial begin
        logic [W-1:0] vec;
        #2;
        check_all();
        #5 rst_n = 1'b1;
        step(1'b1, 16'h8421, 1'b0, 1'b1);
        repeat (6) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'h0000, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'hFFFF, 1'b0, 1'b1);
        for (int i = 0; i < 34; i++) step(1'b0, '0, 1'b0, (i % 2) == 0);
        step(1'b1, 16'h00F0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        step(1'b1, 16'h0002, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'h8000, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'h0C00, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        check("rst.valid_lsb", 32'(vld0), 32'd0);
        check("rst.valid_msb", 32'(vld1), 32'd0);
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0:       vec = '0;
                1:       vec = W'(1) << $urandom_range(0, W-1);
                2:       vec = '1;
                3:       vec = 16'h8000;
                default: vec = W'($urandom);
            endcase
            step($urandom_range(0, 1) == 1, vec, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
